dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Sits between two requesters and the single-port data memory: port 0 is the core load/store unit, port 1 is the debug/DMA loader.
- Round-robin arbitration between the two ports, with a req/done handshake on each.
- Adds byte and half-word access. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the memory writes whole words only.
- Memory side: word-addressed, asynchronous read, synchronous write with a one-bit write enable.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in memory; a word index >= MEM_WORDS is an error.
- PRIO_RESET, 0, port that has priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req  in  1  port 0 request; held with its fields until p0_done
- p0_we  in  1  1 = store, 0 = load
- p0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- p0_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- p0_addr  in  32  byte address
- p0_wdata  in  32  store data, right-aligned
- p0_done  out  1  one-cycle completion pulse
- p0_err  out  1  valid with p0_done: access rejected
- p0_rdata  out  32  load result, valid with p0_done
- p1_* (req, we, size, unsigned, addr, wdata, done, err, rdata): same widths and meaning, port 1
- mem_MemRW  out  1  memory write enable
- mem_addr  out  32  {lat_addr[31:2], 2'b00}
- mem_wdata  out  32  word to write
- mem_rdata  in  32  asynchronous memory read data

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset (asynchronous):
  - state = IDLE; priority pointer = PRIO_RESET.
  - All done, err and rdata outputs = 0.
  - mem_MemRW = 0 immediately; it is decoded from state, never registered separately.
- Arbitration, IDLE state only:
  - If one req is high, grant that port.
  - If both are high, grant the pointer port, then point the pointer at the other port.
  - A grant latches the port id, we, size, unsigned, addr and wdata.
  - req is ignored in RD, WR and RESP.
- Error check at grant:
  - Errors: size = 11; half access with addr[0] = 1; word access with addr[1:0] != 0; addr[31:2] >= MEM_WORDS.
  - An error goes IDLE -> RESP with err = 1 and rdata = 0. The memory is never written.
- Load: IDLE -> RD -> RESP.
  - In RD, lane extract from mem_rdata and register the result (little-endian).
  - Byte lane = addr[1:0]; half lane = addr[1].
- Word store: IDLE -> WR -> RESP.
  - In WR, mem_MemRW = 1 and mem_wdata = lat_wdata.
- Sub-word store: IDLE -> RD -> WR -> RESP.
  - In RD, merge wdata[7:0] or wdata[15:0] into mem_rdata at the lane and register the merged word.
  - In WR, write the merged word.
- Latency, with acceptance in cycle T: error done at T+1; load or word store done at T+2; sub-word store done at T+3.
- RESP state:
  - The granted port's done = 1 for exactly one cycle; err and rdata are also driven to that port.
  - The other port's outputs stay 0.
  - Next state is IDLE. A held req is arbitrated again, so back-to-back accesses from one port cost one idle cycle each.
- Outside WR, mem_MemRW = 0 and mem_wdata holds its last value.
- A requester dropping req mid-transaction is illegal. The transaction still completes and done still pulses.
- Reset mid-transaction aborts it. If it lands during WR, no write occurs: the enable is deasserted asynchronously.

Decomposition:
- Shared package dmem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - a port-id type.
- Sub-module dmem_lane_unit (combinational) takes word, addr[1:0], size, unsigned and wdata. It outputs the extracted, extended load value and the merged store word.

Test Plan:
- p0 word store 0xDEADBEEF to 0x10, then word load from 0x10 -> mem_MemRW high one cycle; p0_done at T+2 both times; p0_rdata = 0xDEADBEEF, p0_err = 0.
- Signed byte load and unsigned half load:
  - Word 0x80FF7F01 at 0x20; signed byte load from 0x23 -> rdata = 0xFFFFFF80.
  - Unsigned half load from 0x22 -> rdata = 0x000080FF.
- p1 byte store 0xAB to 0x21 over 0x11223344 -> done at T+3; the memory word becomes 0x1122AB44.
- p0 and p1 request together from reset (PRIO_RESET = 0), both held -> grants alternate 0,1,0,1; each done pulses on its own port only.
- Misaligned and out-of-range:
  - Half at 0x31 -> done at T+1, err = 1, rdata = 0, no mem_MemRW.
  - Word at 0x400 with MEM_WORDS = 256 -> err = 1.
- Assert rst during WR of a sub-word store -> mem_MemRW drops in the same cycle; the memory word is unchanged; outputs are 0 and the pointer = PRIO_RESET.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 is illegal)
//   - arbiter FSM state enum
//   - requester port id type
//   - access_err(): alignment / size / range check applied at grant time
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef logic port_id_t;

    // An access is rejected for an illegal size, a misaligned half/word, or a
    // word index beyond the end of memory.
    function automatic logic access_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned mem_words);
        logic bad;
        bad = 1'b0;
        if (size == SZ_ILLEGAL)                      bad = 1'b1;
        if (size == SZ_HALF && addr[0])              bad = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00)   bad = 1'b1;
        if ({2'b00, addr[31:2]} >= 32'(mem_words))   bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// -----------------------------------------------------------------------------
// dmem_lane_unit
// Purely combinational little-endian lane logic.
//   word_i      : 32-bit word read from memory
//   addr_lo_i   : byte address bits [1:0]
//   size_i      : access size (dmem_pkg encodings)
//   unsigned_i  : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i     : right-aligned store data
//   load_o      : extracted and extended load value (0 for illegal size)
//   store_o     : word_i with the store data merged into the addressed lane(s)
// -----------------------------------------------------------------------------
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o = '0;
        case (size_i)
            SZ_BYTE: load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            SZ_HALF: load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            SZ_WORD: load_o = word_i;
            default: load_o = '0;
        endcase
    end

    // Each memory byte lane either keeps the old byte or takes a byte of the
    // right-aligned store data: byte stores always source wdata[7:0], half
    // stores source wdata[7:0]/[15:8] depending on the lane's position in the
    // half, word stores pass straight through.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       sel;
            logic [7:0] src;

            always_comb begin
                sel = 1'b0;
                src = wdata_i[8*gi +: 8];
                case (size_i)
                    SZ_BYTE: begin
                        sel = (addr_lo_i == LANE);
                        src = wdata_i[7:0];
                    end
                    SZ_HALF: begin
                        sel = (addr_lo_i[1] == LANE[1]);
                        src = LANE[0] ? wdata_i[15:8] : wdata_i[7:0];
                    end
                    SZ_WORD: begin
                        sel = 1'b1;
                        src = wdata_i[8*gi +: 8];
                    end
                    default: begin
                        sel = 1'b0;
                        src = wdata_i[8*gi +: 8];
                    end
                endcase
            end

            assign store_o[8*gi +: 8] = sel ? src : word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter between two requesters (p0 = core LSU, p1 = debug/DMA)
// in front of a word-wide single-port data memory. Adds byte/half accesses:
// sub-word loads are extracted and extended, sub-word stores are done as
// read-modify-write.
//   clk, rst              : clock, asynchronous active-high reset
//   pN_req/we/size/unsigned/addr/wdata : request, held until pN_done
//   pN_done/err/rdata     : one-cycle completion pulse with status and data
//   mem_MemRW             : memory write enable (decoded from state)
//   mem_addr/mem_wdata    : word-aligned address, write data
//   mem_rdata             : asynchronous read data
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 256,
    parameter bit          PRIO_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_unsigned,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_done,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_unsigned,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mem_MemRW,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    port_id_t    ptr_q;
    port_id_t    gnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] wbuf_q;

    // Grant selection (only meaningful in IDLE)
    logic        any_req;
    logic        both_req;
    port_id_t    sel;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    assign any_req  = p0_req | p1_req;
    assign both_req = p0_req & p1_req;
    assign sel      = both_req ? ptr_q : port_id_t'(p1_req);

    assign sel_we    = sel ? p1_we       : p0_we;
    assign sel_size  = sel ? p1_size     : p0_size;
    assign sel_uns   = sel ? p1_unsigned : p0_unsigned;
    assign sel_addr  = sel ? p1_addr     : p0_addr;
    assign sel_wdata = sel ? p1_wdata    : p0_wdata;
    assign sel_err   = access_err(sel_size, sel_addr, MEM_WORDS);

    logic [31:0] load_val;
    logic [31:0] store_word;

    dmem_lane_unit u_lane (
        .word_i     (mem_rdata),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_val),
        .store_o    (store_word)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    if (sel_err)
                        state_d = ST_RESP;
                    else if (sel_we && sel_size == SZ_WORD)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- latched request / datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= port_id_t'(PRIO_RESET);
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wbuf_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= sel;
                        we_q    <= sel_we;
                        size_q  <= sel_size;
                        uns_q   <= sel_uns;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        err_q   <= sel_err;
                        rdata_q <= '0;
                        // Word stores skip RD, so the write word is loaded here;
                        // otherwise mem_wdata keeps its previous value.
                        if (sel_we && sel_size == SZ_WORD && !sel_err)
                            wbuf_q <= sel_wdata;
                        // Only a contested grant moves the pointer.
                        if (both_req)
                            ptr_q <= ~sel;
                    end
                end
                ST_RD: begin
                    if (we_q) wbuf_q  <= store_word;
                    else      rdata_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_MemRW = (state_q == ST_WR);
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wbuf_q;
        p0_done   = (state_q == ST_RESP) && (gnt_q == 1'b0);
        p1_done   = (state_q == ST_RESP) && (gnt_q == 1'b1);
        p0_err    = p0_done & err_q;
        p1_err    = p1_done & err_q;
        p0_rdata  = p0_done ? rdata_q : '0;
        p1_rdata  = p1_done ? rdata_q : '0;
    end

endmodule
